dcache_controller: RTL and testbench
====================================

# dcache_controller

Write-back, write-allocate data-cache controller that sits between the CPU data port and the unified memory, beside the existing instruction-cache control path. It drives an external direct-mapped cache array (tag/valid/dirty per line) and the shared line-wide memory. It generalises the read-only fetch controller in three ways: line width and address width are parametrised, stores are handled, and dirty victims are written back before a refill.

## Interface
- ADDR_W, 16, word address width from the CPU
- WORD_W, 16, CPU word width
- WORDS_PER_LINE, 4, words per cache line; must be a power of two ≥ 2
- INDEX_W, 3, cache index width; TAG_W = ADDR_W − OFF_W − INDEX_W, where OFF_W = log2(WORDS_PER_LINE) and LINE_W = WORD_W·WORDS_PER_LINE
- clk  in  1  single clock
- rst  in  1  asynchronous, active-high reset
- cpu_addr  in  ADDR_W  word address; held stable until cpu_rdy
- cpu_re / cpu_we  in  1  read / write request; held until cpu_rdy; both high is treated as a write
- cpu_wdata  in  WORD_W  store data
- cpu_rdata  out  WORD_W  load data, valid when cpu_rdy
- cpu_rdy  out  1  request complete this cycle
- c_addr  out  ADDR_W−OFF_W  line address to the cache array
- c_re, c_we, c_wdirty  out  1  cache read enable, write enable, and dirty bit written with the line
- c_wdata  out  LINE_W  line written to the cache
- c_rdata  in  LINE_W; c_tag_out  in  TAG_W; c_hit, c_dirty  in  1  cache lookup results
- m_addr  out  ADDR_W−OFF_W; m_re, m_we  out  1; m_wdata  out  LINE_W  memory request
- m_rdata  in  LINE_W; m_rdy  in  1  memory completion

## Operation
- States: IDLE, WRITEBACK, ALLOCATE.
- **IDLE**, no request:
  - All strobes are 0.
  - cpu_rdy is 0.
  - c_re is 0.
- **IDLE**, request present (c_re=1, c_addr = cpu_addr[ADDR_W−1:OFF_W]):
  - Read hit: cpu_rdata = the word of c_rdata selected by cpu_addr[OFF_W−1:0]; cpu_rdy=1 in the same cycle; stay in IDLE.
  - Write hit: c_wdata = c_rdata with the selected word replaced by cpu_wdata; c_we=1, c_wdirty=1, cpu_rdy=1 in the same cycle.
  - Miss with c_dirty=0: go to ALLOCATE.
  - Miss with c_dirty=1: go to WRITEBACK.
- **WRITEBACK**:
  - Drive m_we=1, m_addr = {c_tag_out, index}, m_wdata = c_rdata.
  - Hold these until m_rdy, then go to ALLOCATE.
  - No cache write occurs in this state.
- **ALLOCATE**:
  - Drive m_re=1, m_addr = cpu line address, until m_rdy.
  - In the m_rdy cycle: c_we=1 and c_wdata = m_rdata, merged with cpu_wdata on a write. c_wdirty = 1 for a write, 0 for a read. cpu_rdata is taken from m_rdata. cpu_rdy=1. Return to IDLE.
- m_rdy is ignored in IDLE.
- m_re and m_we are never both high.
- Reset mid-transaction: the state returns to IDLE immediately and all strobes drop. A memory access in flight is abandoned, and the CPU must reissue.

## Timing
- Reset values: state=IDLE. cpu_rdy, c_re, c_we, c_wdirty, m_re, m_we are all 0. Data outputs are don't-care.
- Hit latency: 0 cycles. cpu_rdy is combinational from c_hit.
- Clean miss: 1 + L cycles, where L is the number of memory cycles to m_rdy.
- Dirty miss: 1 + L_wb + L_fill cycles.
- Memory strobes are level signals. They are deasserted in the cycle after the m_rdy cycle, by the state change.
- The state register is the only sequential element; with the stats macro, the counters are added.

## Configuration
- DCACHE_STATS_EN defined:
  - Adds outputs hit_cnt, miss_cnt, wb_cnt, each 16 bits and saturating.
  - hit_cnt increments on an IDLE hit completion.
  - miss_cnt increments on entry to ALLOCATE or WRITEBACK from IDLE.
  - wb_cnt increments on the WRITEBACK m_rdy cycle.
  - All three are cleared by rst.
- DCACHE_STATS_EN undefined: the ports and counters are absent, and all other behaviour is identical.

## Structure
- Shared package dcache_pkg holds:
  - the state enum (IDLE, WRITEBACK, ALLOCATE);
  - localparam functions for OFF_W, LINE_W and TAG_W.
- Sub-module dcache_line_merge (combinational) holds:
  - word select by offset, giving cpu_rdata;
  - word insert by offset, giving the merged line.
- The controller instantiates dcache_line_merge twice: once for the hit path, once for the fill path.

## Test plan
- Read hit, with c_hit=1 and cpu_addr offset 2 -> cpu_rdata = c_rdata[47:32] and cpu_rdy=1 in the same cycle, with no memory strobe.
- Write hit, cpu_wdata=16'hBEEF at offset 1 -> c_we=1, c_wdirty=1, c_wdata[31:16]=16'hBEEF with the other words unchanged, cpu_rdy=1.
- Clean read miss, with m_rdy after 3 cycles -> m_re high for 3 cycles with m_addr = cpu_addr[15:2]. Then c_we=1, c_wdirty=0, cpu_rdy=1. Total 4 cycles.
- Dirty write miss, with c_tag_out=11'h055 and index 3 -> WRITEBACK: m_we=1, m_addr={11'h055,3'd3}. After m_rdy: ALLOCATE, then merged fill with c_wdirty=1.
- Assert rst during ALLOCATE -> all strobes drop immediately and state=IDLE. After rst releases, a held request restarts from IDLE.
- With DCACHE_STATS_EN: 2 hits, 1 clean miss, 1 dirty miss -> hit_cnt=2, miss_cnt=2, wb_cnt=1.

Source files
------------

// File: rtl/dcache_pkg.sv
// Shared definitions for the write-back data-cache controller.
// Holds the controller state encoding and the width helpers used for port sizing.
// Pure declarations; no logic, no latency, no backpressure.
package dcache_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WRITEBACK = 2'd1,
    ALLOCATE  = 2'd2
  } dcache_state_e;

  // Word-offset width inside a line.
  function automatic int calc_off_w(input int words_per_line);
    return $clog2(words_per_line);
  endfunction

  // Full line width in bits.
  function automatic int calc_line_w(input int word_w, input int words_per_line);
    return word_w * words_per_line;
  endfunction

  // Tag width left over after offset and index bits.
  function automatic int calc_tag_w(input int addr_w, input int words_per_line, input int index_w);
    return addr_w - $clog2(words_per_line) - index_w;
  endfunction

endpackage

// File: rtl/dcache_line_merge.sv
// Word select and word insert on a cache line, indexed by the word offset.
// Purely combinational: zero latency.
// No flow control; outputs follow inputs.
module dcache_line_merge
  import dcache_pkg::*;
#(
  parameter int WORD_W         = 16,
  parameter int WORDS_PER_LINE = 4
) (
  input  logic [calc_line_w(WORD_W, WORDS_PER_LINE)-1:0] line_in,
  input  logic [calc_off_w(WORDS_PER_LINE)-1:0]          offset,
  input  logic [WORD_W-1:0]                              word_in,
  output logic [WORD_W-1:0]                              word_out,
  output logic [calc_line_w(WORD_W, WORDS_PER_LINE)-1:0] line_out
);

  localparam int OFF_W = calc_off_w(WORDS_PER_LINE);

  // Pick the addressed word and build the line with that word replaced.
  always_comb begin
    word_out = line_in[WORD_W-1:0];
    line_out = line_in;
    for (int w = 0; w < WORDS_PER_LINE; w++) begin
      if (offset == OFF_W'(w)) begin
        word_out                     = line_in[w*WORD_W +: WORD_W];
        line_out[w*WORD_W +: WORD_W] = word_in;
      end
    end
  end

endmodule

// File: rtl/dcache_controller.sv
// Write-back, write-allocate direct-mapped data-cache controller (IDLE/WRITEBACK/ALLOCATE).
// Latency: hit 0 cycles; clean miss 1+L; dirty miss 1+L_wb+L_fill (L = cycles to m_rdy).
// Backpressure: CPU request held until cpu_rdy; memory strobes held until m_rdy. DCACHE_STATS_EN adds hit/miss/wb counters.
module dcache_controller
  import dcache_pkg::*;
#(
  parameter int ADDR_W         = 16,
  parameter int WORD_W         = 16,
  parameter int WORDS_PER_LINE = 4,
  parameter int INDEX_W        = 3
) (
  input  logic                                              clk,
  input  logic                                              rst,
  input  logic [ADDR_W-1:0]                                 cpu_addr,
  input  logic                                              cpu_re,
  input  logic                                              cpu_we,
  input  logic [WORD_W-1:0]                                 cpu_wdata,
  output logic [WORD_W-1:0]                                 cpu_rdata,
  output logic                                              cpu_rdy,
  output logic [ADDR_W-calc_off_w(WORDS_PER_LINE)-1:0]      c_addr,
  output logic                                              c_re,
  output logic                                              c_we,
  output logic                                              c_wdirty,
  output logic [calc_line_w(WORD_W, WORDS_PER_LINE)-1:0]    c_wdata,
  input  logic [calc_line_w(WORD_W, WORDS_PER_LINE)-1:0]    c_rdata,
  input  logic [calc_tag_w(ADDR_W, WORDS_PER_LINE, INDEX_W)-1:0] c_tag_out,
  input  logic                                              c_hit,
  input  logic                                              c_dirty,
  output logic [ADDR_W-calc_off_w(WORDS_PER_LINE)-1:0]      m_addr,
  output logic                                              m_re,
  output logic                                              m_we,
  output logic [calc_line_w(WORD_W, WORDS_PER_LINE)-1:0]    m_wdata,
  input  logic [calc_line_w(WORD_W, WORDS_PER_LINE)-1:0]    m_rdata,
  input  logic                                              m_rdy
`ifdef DCACHE_STATS_EN
  ,
  output logic [15:0]                                       hit_cnt,
  output logic [15:0]                                       miss_cnt,
  output logic [15:0]                                       wb_cnt
`endif
);

  localparam int OFF_W  = calc_off_w(WORDS_PER_LINE);
  localparam int LINE_W = calc_line_w(WORD_W, WORDS_PER_LINE);

  localparam logic [1:0] S_IDLE      = IDLE;
  localparam logic [1:0] S_WRITEBACK = WRITEBACK;
  localparam logic [1:0] S_ALLOCATE  = ALLOCATE;

  logic [1:0]              state_q, state_d;
  logic                    req, is_wr;
  logic [ADDR_W-OFF_W-1:0] line_addr;
  logic [OFF_W-1:0]        offset;
  logic [INDEX_W-1:0]      index;
  logic [WORD_W-1:0]       hit_word, fill_word;
  logic [LINE_W-1:0]       hit_line, fill_line;

  assign req       = cpu_re | cpu_we;
  assign is_wr     = cpu_we;            // re+we together is a store
  assign line_addr = cpu_addr[ADDR_W-1:OFF_W];
  assign offset    = cpu_addr[OFF_W-1:0];
  assign index     = cpu_addr[OFF_W+INDEX_W-1:OFF_W];

  // Hit path: read word from / store word into the looked-up line.
  dcache_line_merge #(
    .WORD_W         (WORD_W),
    .WORDS_PER_LINE (WORDS_PER_LINE)
  ) u_hit_merge (
    .line_in  (c_rdata),
    .offset   (offset),
    .word_in  (cpu_wdata),
    .word_out (hit_word),
    .line_out (hit_line)
  );

  // Fill path: same operations on the line returning from memory.
  dcache_line_merge #(
    .WORD_W         (WORD_W),
    .WORDS_PER_LINE (WORDS_PER_LINE)
  ) u_fill_merge (
    .line_in  (m_rdata),
    .offset   (offset),
    .word_in  (cpu_wdata),
    .word_out (fill_word),
    .line_out (fill_line)
  );

  // State register; reset abandons any memory access in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Next state and all strobes; strobes are forced low while rst is high.
  always_comb begin
    state_d   = state_q;
    cpu_rdy   = 1'b0;
    cpu_rdata = hit_word;
    c_addr    = line_addr;
    c_re      = 1'b0;
    c_we      = 1'b0;
    c_wdirty  = 1'b0;
    c_wdata   = hit_line;
    m_addr    = line_addr;
    m_re      = 1'b0;
    m_we      = 1'b0;
    m_wdata   = c_rdata;
    if (!rst) begin
      case (state_q)
        S_IDLE: begin
          if (req) begin
            c_re = 1'b1;
            if (c_hit) begin
              cpu_rdy = 1'b1;
              if (is_wr) begin
                c_we     = 1'b1;
                c_wdirty = 1'b1;
              end
            end else if (c_dirty) begin
              state_d = S_WRITEBACK;
            end else begin
              state_d = S_ALLOCATE;
            end
          end
        end
        S_WRITEBACK: begin
          // Keep the lookup enabled so the victim line and tag stay presented.
          c_re    = 1'b1;
          m_we    = 1'b1;
          m_addr  = {c_tag_out, index};
          m_wdata = c_rdata;
          if (m_rdy) state_d = S_ALLOCATE;
        end
        S_ALLOCATE: begin
          m_re = 1'b1;
          if (m_rdy) begin
            c_we      = 1'b1;
            c_wdirty  = is_wr;
            c_wdata   = is_wr ? fill_line : m_rdata;
            cpu_rdata = fill_word;
            cpu_rdy   = 1'b1;
            state_d   = S_IDLE;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

`ifdef DCACHE_STATS_EN
  logic hit_evt, miss_evt, wb_evt;

  assign hit_evt  = (state_q == S_IDLE) && req && c_hit;
  assign miss_evt = (state_q == S_IDLE) && req && !c_hit;
  assign wb_evt   = (state_q == S_WRITEBACK) && m_rdy;

  // Saturating event counters.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hit_cnt  <= 16'd0;
      miss_cnt <= 16'd0;
      wb_cnt   <= 16'd0;
    end else begin
      if (hit_evt  && hit_cnt  != 16'hFFFF) hit_cnt  <= hit_cnt + 16'd1;
      if (miss_evt && miss_cnt != 16'hFFFF) miss_cnt <= miss_cnt + 16'd1;
      if (wb_evt   && wb_cnt   != 16'hFFFF) wb_cnt   <= wb_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_dcache_controller.sv
// Directed bench for dcache_controller with default parameters (64-bit lines, 14-bit line address).
// Inputs change 1ns after the rising edge; outputs are sampled on the falling edge.
// Stats counters are exercised when DCACHE_STATS_EN is defined.
module tb_dcache_controller;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] cpu_addr;
  logic        cpu_re, cpu_we;
  logic [15:0] cpu_wdata, cpu_rdata;
  logic        cpu_rdy;
  logic [13:0] c_addr;
  logic        c_re, c_we, c_wdirty;
  logic [63:0] c_wdata, c_rdata;
  logic [10:0] c_tag_out;
  logic        c_hit, c_dirty;
  logic [13:0] m_addr;
  logic        m_re, m_we;
  logic [63:0] m_wdata, m_rdata;
  logic        m_rdy;
`ifdef DCACHE_STATS_EN
  logic [15:0] hit_cnt, miss_cnt, wb_cnt;
`endif

  int vectors    = 0;
  int miscompares = 0;

  // {cpu_rdy, c_we, c_wdirty, m_re, m_we}
  logic [4:0] strb;
  assign strb = {cpu_rdy, c_we, c_wdirty, m_re, m_we};

  always #5 clk = ~clk;

  dcache_controller dut (
    .clk       (clk),
    .rst       (rst),
    .cpu_addr  (cpu_addr),
    .cpu_re    (cpu_re),
    .cpu_we    (cpu_we),
    .cpu_wdata (cpu_wdata),
    .cpu_rdata (cpu_rdata),
    .cpu_rdy   (cpu_rdy),
    .c_addr    (c_addr),
    .c_re      (c_re),
    .c_we      (c_we),
    .c_wdirty  (c_wdirty),
    .c_wdata   (c_wdata),
    .c_rdata   (c_rdata),
    .c_tag_out (c_tag_out),
    .c_hit     (c_hit),
    .c_dirty   (c_dirty),
    .m_addr    (m_addr),
    .m_re      (m_re),
    .m_we      (m_we),
    .m_wdata   (m_wdata),
    .m_rdata   (m_rdata),
    .m_rdy     (m_rdy)
`ifdef DCACHE_STATS_EN
    ,
    .hit_cnt   (hit_cnt),
    .miss_cnt  (miss_cnt),
    .wb_cnt    (wb_cnt)
`endif
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    cpu_re = 1'b0; cpu_we = 1'b0; c_hit = 1'b0; c_dirty = 1'b0; m_rdy = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; cpu_addr = 16'h0256; cpu_re = 1'b1; cpu_we = 1'b1; cpu_wdata = 16'h0;
    c_rdata = 64'h0; c_tag_out = 11'h0; c_hit = 1'b1; c_dirty = 1'b0;
    m_rdata = 64'h0; m_rdy = 1'b1;
    @(negedge clk);
    vectors++;
    if (strb !== 5'b00000 || c_re !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_strobes: strb=%b c_re=%b expected strb=00000 c_re=0", strb, c_re);
    end
    step();
    idle_inputs();
    rst = 1'b0;
    @(negedge clk);
    vectors++;
    if (strb !== 5'b00000 || c_re !== 1'b0) begin
      miscompares++;
      $display("FAIL idle_no_req: strb=%b c_re=%b expected strb=00000 c_re=0", strb, c_re);
    end
  endtask

  task automatic test_read_hit();
    step();
    cpu_addr = 16'h0256; cpu_re = 1'b1; c_hit = 1'b1;
    c_rdata = 64'h4444_3333_2222_1111; m_rdy = 1'b1;  // m_rdy must be ignored in IDLE
    @(negedge clk);
    vectors++;
    if (cpu_rdata !== 16'h3333 || strb !== 5'b10000 || c_re !== 1'b1 || c_addr !== 14'h0095) begin
      miscompares++;
      $display("FAIL read_hit_off2: rdata=%h strb=%b c_re=%b c_addr=%h expected 3333 10000 1 0095",
               cpu_rdata, strb, c_re, c_addr);
    end
    step();
    cpu_addr = 16'h0257; m_rdy = 1'b0;
    @(negedge clk);
    vectors++;
    if (cpu_rdata !== 16'h4444 || strb !== 5'b10000) begin
      miscompares++;
      $display("FAIL read_hit_off3: rdata=%h strb=%b expected 4444 10000", cpu_rdata, strb);
    end
    step();
    cpu_addr = 16'h0254;
    @(negedge clk);
    vectors++;
    if (cpu_rdata !== 16'h1111 || strb !== 5'b10000) begin
      miscompares++;
      $display("FAIL read_hit_off0: rdata=%h strb=%b expected 1111 10000", cpu_rdata, strb);
    end
    step();
    idle_inputs();
  endtask

  task automatic test_write_hit();
    cpu_addr = 16'h0255; cpu_we = 1'b1; cpu_wdata = 16'hBEEF; c_hit = 1'b1;
    c_rdata = 64'h4444_3333_2222_1111;
    @(negedge clk);
    vectors++;
    if (c_wdata !== 64'h4444_3333_BEEF_1111 || strb !== 5'b11100) begin
      miscompares++;
      $display("FAIL write_hit_off1: c_wdata=%h strb=%b expected 44443333beef1111 11100", c_wdata, strb);
    end
    step();
    cpu_addr = 16'h0257; cpu_re = 1'b1; cpu_wdata = 16'hCAFE;  // re+we acts as store
    @(negedge clk);
    vectors++;
    if (c_wdata !== 64'hCAFE_3333_2222_1111 || strb !== 5'b11100) begin
      miscompares++;
      $display("FAIL write_hit_re_we: c_wdata=%h strb=%b expected cafe333322221111 11100", c_wdata, strb);
    end
    step();
    idle_inputs();
  endtask

  task automatic test_clean_miss();
    int mre_cycles = 0;
    int lat = 0;
    bit got = 0;
    cpu_addr = 16'h1237; cpu_re = 1'b1; c_hit = 1'b0; c_dirty = 1'b0;
    m_rdata = 64'hDDDD_CCCC_BBBB_AAAA;
    @(negedge clk);
    vectors++;
    if (strb !== 5'b00000 || c_re !== 1'b1) begin
      miscompares++;
      $display("FAIL clean_miss_lookup: strb=%b c_re=%b expected 00000 1", strb, c_re);
    end
    for (int cyc = 0; cyc < 20 && !got; cyc++) begin
      step();
      m_rdy = (cyc == 2);
      @(negedge clk);
      lat++;
      if (m_re) mre_cycles++;
      if (cpu_rdy) begin
        got = 1;
        vectors++;
        if (strb !== 5'b11010 || c_wdata !== 64'hDDDD_CCCC_BBBB_AAAA || cpu_rdata !== 16'hDDDD ||
            m_addr !== 14'h048D) begin
          miscompares++;
          $display("FAIL clean_miss_fill: strb=%b c_wdata=%h rdata=%h m_addr=%h expected 11010 ddddccccbbbbaaaa dddd 048d",
                   strb, c_wdata, cpu_rdata, m_addr);
        end
      end
    end
    vectors++;
    if (!got || mre_cycles != 3 || (1 + lat) != 4) begin
      miscompares++;
      $display("FAIL clean_miss_timing: done=%0d m_re_cycles=%0d total=%0d expected 1 3 4", got, mre_cycles, 1 + lat);
    end
    step();
    idle_inputs();
    @(negedge clk);
    vectors++;
    if (strb !== 5'b00000) begin
      miscompares++;
      $display("FAIL clean_miss_return: strb=%b expected 00000", strb);
    end
  endtask

  task automatic test_dirty_write_miss();
    step();
    cpu_addr = 16'h202E; cpu_we = 1'b1; cpu_wdata = 16'h5A5A;
    c_hit = 1'b0; c_dirty = 1'b1; c_tag_out = 11'h055;
    c_rdata = 64'h0123_4567_89AB_CDEF; m_rdata = 64'h1111_2222_3333_4444;
    @(negedge clk);
    vectors++;
    if (strb !== 5'b00000 || c_re !== 1'b1) begin
      miscompares++;
      $display("FAIL dirty_lookup: strb=%b c_re=%b expected 00000 1", strb, c_re);
    end
    step();
    @(negedge clk);
    vectors++;
    if (strb !== 5'b00001 || m_addr !== 14'h02AB || m_wdata !== 64'h0123_4567_89AB_CDEF) begin
      miscompares++;
      $display("FAIL dirty_wb_wait: strb=%b m_addr=%h m_wdata=%h expected 00001 02ab 0123456789abcdef",
               strb, m_addr, m_wdata);
    end
    step();
    m_rdy = 1'b1;
    @(negedge clk);
    vectors++;
    if (strb !== 5'b00001 || m_addr !== 14'h02AB) begin
      miscompares++;
      $display("FAIL dirty_wb_done: strb=%b m_addr=%h expected 00001 02ab", strb, m_addr);
    end
    step();
    m_rdy = 1'b0;
    @(negedge clk);
    vectors++;
    if (strb !== 5'b00010 || m_addr !== 14'h080B) begin
      miscompares++;
      $display("FAIL dirty_alloc_wait: strb=%b m_addr=%h expected 00010 080b", strb, m_addr);
    end
    step();
    m_rdy = 1'b1;
    @(negedge clk);
    vectors++;
    if (strb !== 5'b11110 || c_wdata !== 64'h1111_5A5A_3333_4444) begin
      miscompares++;
      $display("FAIL dirty_fill_merge: strb=%b c_wdata=%h expected 11110 11115a5a33334444", strb, c_wdata);
    end
    step();
    idle_inputs();
  endtask

  task automatic test_reset_mid();
    cpu_addr = 16'h1237; cpu_re = 1'b1; c_hit = 1'b0; c_dirty = 1'b0;
    m_rdata = 64'hDDDD_CCCC_BBBB_AAAA;
    step();
    @(negedge clk);
    vectors++;
    if (strb !== 5'b00010) begin
      miscompares++;
      $display("FAIL rst_mid_alloc: strb=%b expected 00010", strb);
    end
    #2 rst = 1'b1;
    #1;
    vectors++;
    if (strb !== 5'b00000 || c_re !== 1'b0) begin
      miscompares++;
      $display("FAIL rst_mid_drop: strb=%b c_re=%b expected 00000 0", strb, c_re);
    end
    step();
    rst = 1'b0;
    @(negedge clk);
    vectors++;
    if (strb !== 5'b00000 || c_re !== 1'b1) begin
      miscompares++;
      $display("FAIL rst_mid_restart_idle: strb=%b c_re=%b expected 00000 1", strb, c_re);
    end
    step();
    @(negedge clk);
    vectors++;
    if (strb !== 5'b00010) begin
      miscompares++;
      $display("FAIL rst_mid_realloc: strb=%b expected 00010", strb);
    end
    step();
    m_rdy = 1'b1;
    @(negedge clk);
    vectors++;
    if (strb !== 5'b11010 || cpu_rdata !== 16'hDDDD) begin
      miscompares++;
      $display("FAIL rst_mid_complete: strb=%b rdata=%h expected 11010 dddd", strb, cpu_rdata);
    end
    step();
    idle_inputs();
  endtask

`ifdef DCACHE_STATS_EN
  task automatic test_stats();
    rst = 1'b1;
    step();
    rst = 1'b0;
    @(negedge clk);
    vectors++;
    if (hit_cnt !== 16'd0 || miss_cnt !== 16'd0 || wb_cnt !== 16'd0) begin
      miscompares++;
      $display("FAIL stats_reset: hit=%0d miss=%0d wb=%0d expected 0 0 0", hit_cnt, miss_cnt, wb_cnt);
    end
    step();
    cpu_addr = 16'h0256; cpu_re = 1'b1; c_hit = 1'b1;
    step();
    cpu_re = 1'b0; cpu_we = 1'b1; cpu_wdata = 16'h1234;
    step();
    cpu_we = 1'b0; cpu_re = 1'b1; c_hit = 1'b0; c_dirty = 1'b0;
    step();
    m_rdy = 1'b1;
    step();
    idle_inputs();
    cpu_we = 1'b1; c_dirty = 1'b1;
    step();
    m_rdy = 1'b1;
    step();
    step();
    idle_inputs();
    @(negedge clk);
    vectors++;
    if (hit_cnt !== 16'd2 || miss_cnt !== 16'd2 || wb_cnt !== 16'd1) begin
      miscompares++;
      $display("FAIL stats_counts: hit=%0d miss=%0d wb=%0d expected 2 2 1", hit_cnt, miss_cnt, wb_cnt);
    end
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_read_hit();
    test_write_hit();
    test_clean_miss();
    test_dirty_write_miss();
    test_reset_mid();
`ifdef DCACHE_STATS_EN
    test_stats();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
